// File: rtl/fp_normalize_round.sv
// Normalise-and-round stage behind the floating-point adder.
// Takes a raw sum (sign, signed biased exponent, mantissa with carry, hidden,
// fraction, guard and sticky bits). It shifts one bit per cycle until the
// mantissa is normalised or the value is denormalised to exponent 1. It then
// rounds to nearest-even and packs an IEEE-754 word with overflow and inexact
// flags.
//
// Handshake: an input is taken on a rising edge where valid_i & ready_o.
// A result is handed over on a rising edge where valid_o & ready_i. Each valid
// stays asserted and its data stays stable until the matching ready is seen.
module fp_normalize_round #(
    parameter int b = 32,
    parameter int e = 8,
    parameter int m = 23
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic         isaret_i,
    input  logic [e+1:0] us_i,
    input  logic [m+3:0] mantis_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [b-1:0] sonuc_o,
    output logic         tasma_o,
    output logic         kesin_degil_o,
    output logic [1:0]   dbg_state_o
);

    // One spare bit above the input exponent, so that +1 steps never wrap.
    localparam int XW = e + 3;
    localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << e) - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic                 sign_q, sign_d;
    logic signed [XW-1:0] exp_q, exp_d;
    logic [m+3:0]         mant_q, mant_d;
    logic [b-1:0]         sonuc_q, sonuc_d;
    logic                 tasma_q, tasma_d;
    logic                 inexact_q, inexact_d;

    logic                 guard_w;
    logic                 sticky_w;
    logic                 round_up_w;
    logic [m+1:0]         sum_w;
    logic signed [XW-1:0] exp_r_w;
    logic [m-1:0]         frac_w;
    logic                 normal_w;
    logic                 ovf_w;
    logic [b-1:0]         packed_w;

    // Rounding and packing of the current mantissa/exponent (used in ROUND)
    always_comb begin
        guard_w    = mant_q[1];
        sticky_w   = mant_q[0];
        round_up_w = guard_w & (sticky_w | mant_q[2]);
        sum_w      = {1'b0, mant_q[m+2:2]} + {{(m+1){1'b0}}, round_up_w};
        if (sum_w[m+1]) begin
            exp_r_w = exp_q + EXP_ONE;
            frac_w  = '0;
        end else begin
            exp_r_w = exp_q;
            frac_w  = sum_w[m-1:0];
        end
        // A subnormal that rounds into the hidden bit becomes normal at exponent 1.
        normal_w = sum_w[m+1] | sum_w[m];
        ovf_w    = normal_w && (exp_r_w >= EXP_MAX);
        if (ovf_w) begin
            packed_w = {sign_q, {e{1'b1}}, {m{1'b0}}};
        end else if (normal_w) begin
            packed_w = {sign_q, exp_r_w[e-1:0], frac_w};
        end else begin
            packed_w = {sign_q, {e{1'b0}}, frac_w};
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        mant_d    = mant_q;
        sonuc_d   = sonuc_q;
        tasma_d   = tasma_q;
        inexact_d = inexact_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    if (mantis_i == '0) begin
                        // Zero takes one pass through ROUND, which packs +0 with clear flags.
                        sign_d  = 1'b0;
                        exp_d   = EXP_ONE;
                        mant_d  = '0;
                        state_d = ST_ROUND;
                    end else begin
                        sign_d  = isaret_i;
                        exp_d   = {us_i[e+1], us_i};
                        mant_d  = mantis_i;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (mant_q[m+3] || (exp_q < EXP_ONE)) begin
                    // Right shift; the dropped bit folds into sticky.
                    mant_d = {1'b0, mant_q[m+3:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + EXP_ONE;
                end else if (!mant_q[m+2] && (exp_q > EXP_ONE)) begin
                    mant_d = {mant_q[m+2:0], 1'b0};
                    exp_d  = exp_q - EXP_ONE;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                sonuc_d   = packed_w;
                tasma_d   = ovf_w;
                inexact_d = ovf_w | guard_w | sticky_w;
                state_d   = ST_DONE;
            end
            default: begin
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State and result registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mant_q    <= '0;
            sonuc_q   <= '0;
            tasma_q   <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            mant_q    <= mant_d;
            sonuc_q   <= sonuc_d;
            tasma_q   <= tasma_d;
            inexact_q <= inexact_d;
        end
    end

    assign ready_o       = (state_q == ST_IDLE);
    assign valid_o       = (state_q == ST_DONE);
    assign sonuc_o       = sonuc_q;
    assign tasma_o       = tasma_q;
    assign kesin_degil_o = inexact_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Bench for fp_normalize_round. It runs directed cases with hand-derived
// results, then random operands. The random operands are checked against an
// exact-arithmetic round-to-nearest-even model.
module tb_fp_normalize_round;

    localparam int B       = 32;
    localparam int E       = 8;
    localparam int M       = 23;
    localparam int W       = B + 2;
    localparam int TIMEOUT = 400;

    logic         clk_i    = 1'b0;
    logic         rst_i    = 1'b1;
    logic         valid_i  = 1'b0;
    logic         isaret_i = 1'b0;
    logic         ready_i  = 1'b0;
    logic [E+1:0] us_i     = '0;
    logic [M+3:0] mantis_i = '0;
    logic         ready_o;
    logic         valid_o;
    logic [B-1:0] sonuc_o;
    logic         tasma_o;
    logic         kesin_degil_o;
    logic [1:0]   dbg_state_o;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    fp_normalize_round #(.b(B), .e(E), .m(M)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .isaret_i      (isaret_i),
        .us_i          (us_i),
        .mantis_i      (mantis_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .sonuc_o       (sonuc_o),
        .tasma_o       (tasma_o),
        .kesin_degil_o (kesin_degil_o),
        .dbg_state_o   (dbg_state_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [M+3:0] bit1(input int i);
        logic [M+3:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference: the operand is the exact value mt * 2^(us - M - 2) in biased-exponent terms.
    // It is rounded to nearest-even into the target format. Returns {overflow, inexact, word}.
    function automatic logic [W-1:0] model(input logic s, input int us, input logic [M+3:0] mt);
        longint unsigned x, q, rem, half;
        int p, ebig, eq, d;
        logic inexact;
        logic [B-1:0] word;
        x = 64'(mt);
        if (x == 0) return '0;
        p = 0;
        for (int i = 0; i < M + 4; i++) if (mt[i]) p = i;
        ebig = us + p - (M + 2);
        eq   = (ebig >= 1) ? ebig : 1;
        d    = eq + 2 - us;
        rem  = 0;
        if (d <= 0) begin
            q = x << (-d);
        end else if (d > 60) begin
            q   = 0;
            rem = x;
        end else begin
            q    = x >> d;
            rem  = x & ((64'd1 << d) - 64'd1);
            half = 64'd1 << (d - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        end
        inexact = (rem != 0);
        if (q == (64'd1 << (M + 1))) begin
            q  = q >> 1;
            eq = eq + 1;
        end
        if (q >= (64'd1 << M)) begin
            if (eq >= (1 << E) - 1) return {2'b11, s, {E{1'b1}}, {M{1'b0}}};
            word = {s, eq[E-1:0], q[M-1:0]};
        end else begin
            word = {s, {E{1'b0}}, q[M-1:0]};
        end
        return {1'b0, inexact, word};
    endfunction

    // Driver: present one operand and leave right after its acceptance edge
    task automatic send(input logic s, input int us, input logic [M+3:0] mt, input logic [W-1:0] expv);
        @(negedge clk_i);
        isaret_i = s;
        us_i     = us[E+1:0];
        mantis_i = mt;
        valid_i  = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i  = 1'b0;
        exp_q.push_back(expv);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (valid_o !== 1'b1 && lat < TIMEOUT) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        check("valid_seen", 64'(valid_o), 64'd1);
    endtask

    // Scoreboard: compare the presented result with the oldest expectation
    task automatic check_result(input string tag);
        logic [W-1:0] ev;
        check({tag, "_outstanding"}, 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            check({tag, "_word"},    64'(sonuc_o),       64'(ev[B-1:0]));
            check({tag, "_inexact"}, 64'(kesin_degil_o), 64'(ev[B]));
            check({tag, "_ovf"},     64'(tasma_o),       64'(ev[B+1]));
        end
    endtask

    task automatic release_out(input int hold);
        repeat (hold) begin
            @(posedge clk_i);
            #1;
        end
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        check("valid_drop", 64'(valid_o), 64'd0);
        check("ready_back", 64'(ready_o), 64'd1);
    endtask

    task automatic directed(input string tag, input logic s, input int us, input logic [M+3:0] mt,
                            input logic [W-1:0] expv, input int exp_lat);
        int lat;
        send(s, us, mt, expv);
        wait_valid(lat);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_result(tag);
        release_out(0);
    endtask

    initial begin
        int lat;
        logic [31:0] r;
        logic [M+3:0] mt;
        int us;
        int kind;

        // Reset
        #1 rst_i = 1'b0;
        #20;
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_word",  64'(sonuc_o), 64'd0);
        check("rst_ovf",   64'(tasma_o), 64'd0);
        check("rst_inex",  64'(kesin_degil_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Directed cases with hand-derived results
        directed("carry",   1'b0, 127, bit1(M+3),                     {2'b00, 32'h4000_0000}, 3);
        directed("cancel",  1'b0, 127, bit1(2),                       {2'b00, 32'h3400_0000}, 25);
        directed("tie_ev",  1'b0, 127, bit1(M+2) | bit1(1),           {2'b01, 32'h3F80_0000}, 2);
        directed("tie_od",  1'b0, 127, bit1(M+2) | bit1(2) | bit1(1), {2'b01, 32'h3F80_0002}, 2);
        directed("ovf",     1'b1, 254, bit1(M+3),                     {2'b11, 32'hFF80_0000}, 3);
        directed("zero",    1'b1, 127, '0,                            {2'b00, 32'h0000_0000}, 1);
        directed("subn",    1'b0, 1,   bit1(M+1),                     {2'b00, 32'h0040_0000}, 2);

        // Back-pressure: result held, new operand ignored
        send(1'b0, 127, bit1(M+2) | bit1(2) | bit1(1), {2'b01, 32'h3F80_0002});
        wait_valid(lat);
        isaret_i = 1'b1;
        us_i     = 10'd200;
        mantis_i = bit1(M+3);
        valid_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            check("hold_valid", 64'(valid_o), 64'd1);
            check("hold_word",  64'(sonuc_o), 64'h3F80_0002);
            check("hold_ready", 64'(ready_o), 64'd0);
        end
        valid_i = 1'b0;
        check_result("hold");
        release_out(0);

        // Asynchronous reset in the middle of a long normalisation
        send(1'b0, 127, bit1(2), {2'b00, 32'h3400_0000});
        repeat (3) @(posedge clk_i);
        #1;
        check("busy_ready", 64'(ready_o), 64'd0);
        #1;
        rst_i = 1'b0;
        #1;
        check("abort_valid", 64'(valid_o), 64'd0);
        check("abort_ready", 64'(ready_o), 64'd1);
        check("abort_word",  64'(sonuc_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        exp_q.delete();
        directed("after_rst", 1'b0, 127, bit1(M+3), {2'b00, 32'h4000_0000}, 3);

        // Random operands against the model
        for (int n = 0; n < 40; n++) begin
            r    = $urandom;
            mt   = r[M+3:0];
            kind = int'($urandom_range(0, 3));
            case (kind)
                1: mt[M+3] = 1'b1;
                2: begin
                    mt      = '0;
                    mt[7:0] = r[7:0];
                end
                3: begin
                    mt[M+3] = 1'b0;
                    mt[M+2] = 1'b1;
                end
                default: ;
            endcase
            us = int'($urandom_range(0, 330)) - 20;
            r  = $urandom;
            send(r[0], us, mt, model(r[0], us, mt));
            wait_valid(lat);
            check_result("rand");
            release_out(int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
